// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial LSB-first a - b using one full-subtractor cell and a registered borrow.
module serial_subtractor #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             d_bit,
   output logic             d_valid
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t           r_state, w_next;
   logic [WIDTH-1:0] r_sa, r_sb, r_res, r_diff, w_res_next;
   logic [CNT_W-1:0] r_cnt;
   logic             r_borrow, r_bout, w_d, w_nb, w_last;
   assign w_d        = r_sa[0] ^ r_sb[0] ^ r_borrow;
   assign w_nb       = (~r_sa[0] & r_sb[0]) | (~(r_sa[0] ^ r_sb[0]) & r_borrow);
   assign w_res_next = {w_d, r_res[WIDTH-1:1]};
   assign w_last     = r_cnt == CNT_W'(WIDTH - 1);
   always_comb begin
      w_next = r_state;
      if (r_state == IDLE && start) w_next = SHIFT;
      else if (r_state == SHIFT && w_last) w_next = DONE;
      else if (r_state == DONE) w_next = IDLE;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_sa     <= '0;
         r_sb     <= '0;
         r_res    <= '0;
         r_diff   <= '0;
         r_borrow <= 1'b0;
         r_bout   <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && start) begin
            r_sa     <= a;
            r_sb     <= b;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
         end else if (r_state == SHIFT) begin
            r_sa     <= r_sa >> 1;
            r_sb     <= r_sb >> 1;
            r_res    <= w_res_next;
            r_borrow <= w_nb;
            r_cnt    <= r_cnt + 1'b1;
            if (w_last) begin
               r_diff <= w_res_next;
               r_bout <= w_nb;
            end
         end
      end
   end
   // d_bit is gated so a leftover borrow cannot show through while idle
   assign busy    = r_state == SHIFT;
   assign done    = r_state == DONE;
   assign d_valid = busy;
   assign d_bit   = busy & w_d;
   assign diff    = r_diff;
   assign bout    = r_bout;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: random and directed checks of serial_subtractor against an arithmetic model.
module tb_serial_subtractor;
   localparam int W = 8;
   logic         clk = 0, rst_n = 0, start = 0;
   logic [W-1:0] a = 0, b = 0, diff;
   logic         busy, done, bout, d_bit, d_valid;
   int           tests = 0, fails = 0, done_cnt = 0;
   logic [W-1:0] dseq = 0;
   int           m_ph = -1;
   logic [W-1:0] m_val = 0, m_diff = 0;
   logic         m_b = 0, m_bout = 0;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(W), .CNT_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .busy(busy), .done(done),
      .diff(diff), .bout(bout), .d_bit(d_bit), .d_valid(d_valid));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // model: phase counts cycles since the accepting edge; result is plain 9-bit subtraction
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ph = -1; m_diff = 0; m_bout = 0;
      end else if (m_ph < 0) begin
         if (start) begin
            {m_b, m_val} = {1'b0, a} - {1'b0, b};
            m_ph = 0;
         end
      end else if (m_ph == W) m_ph = -1;
      else begin
         m_ph++;
         if (m_ph == W) begin m_diff = m_val; m_bout = m_b; end
      end
   end

   always @(negedge clk) begin
      logic busy_e, done_e, dbit_e;
      if (rst_n) begin
         busy_e = m_ph >= 0 && m_ph < W;
         done_e = m_ph == W;
         dbit_e = 1'b0;
         if (busy_e) dbit_e = m_val[m_ph];
         chk("cycle{busy,done,dv,dbit,bout,diff}", {20'd0, busy, done, d_valid, d_bit, bout, diff},
             {20'd0, busy_e, done_e, busy_e, dbit_e, m_bout, m_diff});
         if (done) done_cnt++;
         if (busy) dseq = {d_bit, dseq[W-1:1]};
      end
   end

   task automatic wait_done();
      for (int i = 0; i < 40; i++) begin
         @(negedge clk); #1;
         if (done) return;
      end
      chk("done_timeout", 0, 1);
   endtask

   task automatic op(input logic [W-1:0] xa, input logic [W-1:0] xb);
      @(negedge clk);
      a = xa; b = xb; start = 1;
      @(negedge clk);
      start = 0; a = W'($urandom); b = W'($urandom);
      wait_done();
   endtask

   initial begin
      int dc, t0, tl;
      repeat (2) @(negedge clk);
      chk("reset_outputs", {busy, done, d_bit, d_valid, bout, diff}, 0);
      rst_n = 1;
      dseq = 0;
      op(8'h05, 8'h03);
      chk("dseq_05_03", dseq, 8'h02);
      chk("diff_05_03", {bout, diff}, {1'b0, 8'h02});
      op(8'h03, 8'h05); chk("diff_03_05", {bout, diff}, {1'b1, 8'hFE});
      op(8'h00, 8'hFF); chk("diff_00_FF", {bout, diff}, {1'b1, 8'h01});
      op(8'hFF, 8'h01); chk("diff_FF_01", {bout, diff}, {1'b0, 8'hFE});
      op(8'hA5, 8'hA5); chk("diff_A5_A5", {bout, diff}, {1'b0, 8'h00});
      dc = done_cnt;
      op(8'h00, 8'h00); chk("diff_00_00", {bout, diff}, {1'b0, 8'h00});
      repeat (3) @(negedge clk);
      chk("done_once_00", done_cnt - dc, 1);
      // second request during SHIFT must be dropped
      dc = done_cnt;
      @(negedge clk); a = 8'h10; b = 8'h01; start = 1;
      @(negedge clk); start = 0;
      repeat (2) @(negedge clk);
      a = 8'hFF; b = 8'h00; start = 1;
      @(negedge clk); start = 0;
      wait_done();
      chk("diff_ignore", {bout, diff}, {1'b0, 8'h0F});
      repeat (15) @(negedge clk);
      chk("done_once_ignore", done_cnt - dc, 1);
      op(8'h20, 8'h03); chk("diff_after_ignore", {bout, diff}, {1'b0, 8'h1D});
      // asynchronous abort mid-shift
      dc = done_cnt;
      @(negedge clk); a = 8'h77; b = 8'h11; start = 1;
      @(negedge clk); start = 0;
      repeat (3) @(negedge clk);
      #2 rst_n = 0;
      #1 chk("async_reset_outputs", {busy, done, d_bit, d_valid, bout, diff}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1;
      repeat (12) @(negedge clk);
      chk("no_done_after_abort", done_cnt - dc, 0);
      op(8'h80, 8'h7F); chk("diff_80_7F", {bout, diff}, {1'b0, 8'h01});
      // start held high: done every W+2 cycles
      @(negedge clk); a = 8'h09; b = 8'h04; start = 1;
      t0 = -1; tl = 0;
      for (int i = 0; i < 36; i++) begin
         @(negedge clk); #1;
         if (busy && done) chk("busy_in_done", 1, 0);
         if (done) begin
            chk("diff_09_04", {bout, diff}, {1'b0, 8'h05});
            if (t0 >= 0) chk("done_period", i - t0, W + 2);
            t0 = i; tl++;
         end
      end
      chk("done_count_held", tl, 3);
      start = 0;
      repeat (12) @(negedge clk);
      for (int i = 0; i < 40; i++) begin
         logic [W-1:0] ra, rb;
         ra = W'($urandom); rb = W'($urandom);
         if (i == 0) begin ra = 8'hFF; rb = 8'hFF; end
         if (i == 1) begin ra = 8'h00; rb = 8'h01; end
         op(ra, rb);
         chk("rand_diff", {bout, diff}, {ra < rb, W'(ra - rb)});
      end
      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
